// File: rtl/serial_signed_subtractor_4bit_pkg.sv
// Shared arithmetic package for the serial signed subtractor.
// Contents:
//   DEFAULT_WIDTH - default operand/result width in bits
//   state_t       - state encoding of the control FSM (IDLE, RUN, DONE)
package serial_signed_subtractor_4bit_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_signed_subtractor_4bit_if.sv
// Handshake and data bundle of the serial signed subtractor.
// Signals:
//   start    - request, from the master
//   A, B     - signed minuend / subtrahend, from the master
//   DIFF     - result A - B modulo 2^WIDTH, to the master
//   overflow - signed overflow of the last result, to the master
//   busy     - bits are being processed, to the master
//   done     - one-cycle pulse when DIFF/overflow update, to the master
interface serial_signed_subtractor_4bit_if #(
  parameter int WIDTH = serial_signed_subtractor_4bit_pkg::DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] DIFF;
  logic             overflow;
  logic             busy;
  logic             done;

  modport master (output start, A, B, input DIFF, overflow, busy, done);
  modport slave  (input start, A, B, output DIFF, overflow, busy, done);
endinterface

// File: rtl/serial_signed_subtractor_4bit_full_adder.sv
// One-bit full-adder cell shared by the arithmetic datapath.
// Ports:
//   a, b, cin - addend bits and carry in
//   s, cout   - sum bit and carry out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_signed_subtractor_4bit.sv
// Bit-serial two's-complement subtractor: DIFF = A - B, one bit per clock,
// LSB first, computed as A + ~B + 1 through a single full-adder cell whose
// carry is closed through a flop.
// Ports:
//   clk - clock, rising edge
//   rst - synchronous active-high reset
//   bus - slave side of the start/busy/done handshake with A, B, DIFF, overflow
module serial_signed_subtractor_4bit #(
  parameter int WIDTH = serial_signed_subtractor_4bit_pkg::DEFAULT_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  serial_signed_subtractor_4bit_if.slave  bus
);
  import serial_signed_subtractor_4bit_pkg::*;

  localparam int              CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_reg;
  logic [WIDTH-1:0] diff_reg;
  logic [CW-1:0]    cnt_reg;
  logic             carry_reg;
  logic             ovf_reg;
  logic             busy_reg;
  logic             done_reg;

  logic             b_inv;
  logic             sum_bit;
  logic             carry_out;
  logic [WIDTH-1:0] res_next;

  assign b_inv = ~b_reg[0];

  full_adder u_fa (
    .a    (a_reg[0]),
    .b    (b_inv),
    .cin  (carry_reg),
    .s    (sum_bit),
    .cout (carry_out)
  );

  // Sum bits enter from the MSB side so that after WIDTH shifts bit 0 of the
  // result has reached the LSB position.
  assign res_next = {sum_bit, res_reg[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      diff_reg  <= '0;
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      ovf_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            a_reg     <= bus.A;
            b_reg     <= bus.B;
            carry_reg <= 1'b1;  // the +1 of A + ~B + 1
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= ST_RUN;
          end else begin
            state_reg <= ST_IDLE;
          end
        end
        ST_RUN: begin
          a_reg     <= a_reg >> 1;
          b_reg     <= b_reg >> 1;
          res_reg   <= res_next;
          carry_reg <= carry_out;
          cnt_reg   <= cnt_reg + CW'(1);
          if (cnt_reg == LAST) begin
            diff_reg  <= res_next;
            // carry_reg here is the carry into the MSB
            ovf_reg   <= carry_reg ^ carry_out;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= ST_DONE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.DIFF     = diff_reg;
  assign bus.overflow = ovf_reg;
  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;

endmodule

// File: tb/tb_serial_signed_subtractor_4bit.sv
// Self-checking bench for serial_signed_subtractor_4bit (WIDTH=4): directed
// vectors, exhaustive sweep, back-to-back streaming, reset abort and random
// operations, all against a signed-arithmetic reference model.
module tb_serial_signed_subtractor_4bit;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [W-1:0] exp_diff;
  logic         exp_ov;

  always #5 clk = ~clk;

  serial_signed_subtractor_4bit_if #(.WIDTH(W)) bus ();

  serial_signed_subtractor_4bit #(.WIDTH(W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference: signed difference with plain integer arithmetic; overflow when
  // the true difference falls outside the W-bit signed range.
  function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    int d;
    logic [31:0] du;
    logic ov;
    d  = int'($signed(a)) - int'($signed(b));
    ov = (d < -(1 << (W - 1))) || (d > (1 << (W - 1)) - 1);
    du = d;
    return {ov, du[W-1:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
    int lat;
    int busy_cnt;
    logic [W:0] r;
    r        = ref_sub(a, b);
    @(negedge clk);
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.A     = ~a;  // later changes must not reach the result
    bus.B     = ~b;
    lat      = 0;
    busy_cnt = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      if (bus.busy === 1'b1) busy_cnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    exp_diff = r[W-1:0];
    exp_ov   = r[W];
    chk("latency", lat, W);
    chk("busy_cycles", busy_cnt, W);
    chk("busy_in_done", bus.busy, 0);
    chk("diff", bus.DIFF, exp_diff);
    chk("overflow", bus.overflow, exp_ov);
    $display("[TB] op A=%0d B=%0d DIFF=%0d ov=%0b lat=%0d",
             $signed(a), $signed(b), $signed(bus.DIFF), bus.overflow, lat);
    @(posedge clk);
    #1;
    chk("done_pulse_width", bus.done, 0);
    chk("diff_hold", bus.DIFF, exp_diff);
  endtask

  initial begin
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    logic [W-1:0] ra, rb;
    logic [W:0]   r;
    bit           saw_done;

    // Reset, with start asserted at the same time: reset must win.
    rst = 1'b1;
    bus.start = 1'b1;
    bus.A = 4'd3;
    bus.B = 4'd1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_diff", bus.DIFF, 0);
    chk("rst_ov", bus.overflow, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    exp_diff = '0;
    exp_ov   = 1'b0;
    $display("[TB] reset done");

    // Directed vectors
    run_op(4'b0011, 4'b0101);
    chk("dir_3m5", bus.DIFF, 4'b1110);
    run_op(4'b0111, 4'b1111);
    chk("dir_7mm1_ov", bus.overflow, 1);
    run_op(4'b1000, 4'b0001);
    chk("dir_m8m1", bus.DIFF, 4'b0111);
    run_op(4'b1000, 4'b1000);
    chk("dir_m8mm8", bus.DIFF, 4'b0000);
    run_op(4'b0000, 4'b1000);
    chk("dir_0mm8_ov", bus.overflow, 1);

    // Back-to-back: start held every cycle with changing operands. Accepts land
    // on every fifth edge; results come out four edges after each accept.
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      ra = 4'($urandom);
      rb = 4'($urandom);
      bus.A = ra;
      bus.B = rb;
      bus.start = 1'b1;
      if (k % 5 == 0) begin
        qa.push_back(ra);
        qb.push_back(rb);
      end
      @(posedge clk);
      #1;
      chk("b2b_done", bus.done, (k % 5 == 4));
      chk("b2b_busy", bus.busy, (k % 5 != 4));
      if (k % 5 == 4 && qa.size() > 0) begin
        r = ref_sub(qa.pop_front(), qb.pop_front());
        exp_diff = r[W-1:0];
        exp_ov   = r[W];
        $display("[TB] b2b result k=%0d DIFF=%0d ov=%0b", k, $signed(bus.DIFF), bus.overflow);
      end
      chk("b2b_diff", bus.DIFF, exp_diff);
      chk("b2b_ov", bus.overflow, exp_ov);
    end
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_queue_empty", qa.size(), 0);
    @(posedge clk);
    #1;

    // Reset after bit 2 of 6-2: aborted with no done pulse.
    @(negedge clk);
    bus.A = 4'd6;
    bus.B = 4'd2;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_diff", bus.DIFF, 0);
    chk("abort_ov", bus.overflow, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) saw_done = 1'b1;
    end
    chk("abort_no_done", saw_done, 0);
    $display("[TB] abort done");
    run_op(4'd6, 4'd2);
    chk("after_abort", bus.DIFF, 4'b0100);

    // Exhaustive sweep
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        run_op(4'(a), 4'(b));

    // Random operations
    repeat (20) run_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_signed_subtractor_4bit.md
# serial_signed_subtractor_4bit

- Bit-serial two's-complement subtractor: computes DIFF = A − B on WIDTH-bit signed operands, one bit per clock, LSB first, with signed-overflow detection.
- Pairs with the team's combinational signed adder and provides the subtract direction of the same arithmetic datapath.
- Trades latency for area: a single full-adder cell plus one carry flop, driven by a start/busy/done handshake.

## Interface

- Parameter `WIDTH`, default 4: operand and result width in bits, two's complement, minimum 2.
- Port `clk`, input, 1: the single clock; all state changes on its rising edge.
- Port `rst`, input, 1: reset, synchronous and active-high.
- Port `start`, input, 1: request; sampled only when the block can accept (see Operation).
- Port `A`, input, WIDTH: minuend, signed; sampled on the accepting edge only.
- Port `B`, input, WIDTH: subtrahend, signed; sampled on the accepting edge only.
- Port `DIFF`, output, WIDTH: result A − B modulo 2^WIDTH; held until the next result.
- Port `overflow`, output, 1: signed overflow of the last result; held with DIFF.
- Port `busy`, output, 1: high while bits are being processed.
- Port `done`, output, 1: one-cycle pulse when DIFF/overflow update.

## Operation

- State machine with states IDLE, RUN, DONE.
  - IDLE: `start`=1 → latch A and B into shift registers; carry flop := 1 (the +1 of A + ~B + 1); bit counter := 0; go to RUN.
  - RUN: each edge applies a_i, ~b_i and carry to the full-adder cell. The sum bit shifts into the result shift register from the MSB side; carry flop := carry out; counter increments.
  - RUN exit: on the edge that processes bit WIDTH−1, go to DONE. On that same edge:
    - DIFF := completed result.
    - overflow := carry into bit WIDTH−1 XOR carry out of bit WIDTH−1.
    - done := 1.
  - DONE: lasts exactly one cycle. `start`=1 here is accepted exactly as in IDLE (back-to-back operation, → RUN). Otherwise → IDLE.
- `start` in RUN is ignored; the operands are not re-sampled.
- DIFF and overflow change only on a completing edge or on reset. They stay stable through IDLE and through the next operation's RUN.
- Arithmetic: DIFF wraps modulo 2^WIDTH; the carry out of the MSB is discarded.
- Reset:
  - `rst`=1 at any edge, including mid-RUN: state := IDLE; DIFF, overflow, busy, done := 0; shift registers, counter and carry := 0.
  - Any in-flight operation is aborted with no done pulse.
  - Reset wins over a simultaneous `start`.

## Timing

- Accepting edge = E0. Bits 0..WIDTH−1 are processed at edges E1..E(WIDTH).
- `busy` is high from after E0 until E(WIDTH); it is low during the DONE cycle.
- DIFF, overflow and `done` update at E(WIDTH): latency is WIDTH cycles from accept to result (4 for the default).
- `done` is high for exactly one cycle, after E(WIDTH) until E(WIDTH+1).
- Back-to-back: `start` held high during DONE is accepted at E(WIDTH+1). Sustained throughput is one result per WIDTH+1 cycles.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Structure

- Shared arithmetic package holds the state encoding constants (IDLE, RUN, DONE) and the default WIDTH.
- Sub-module: one instance of the existing `full_adder` cell, with b fed inverted and the carry closed through the carry flop. No new arithmetic cell is created.
- Counter width is ceil(log2(WIDTH)) bits.
- Overflow needs the carry into the MSB. Capture it as the carry flop value present when bit WIDTH−1 is processed; no extra adder is used.

## Test plan

- A=0011 (3), B=0101 (5), start one cycle → after 4 cycles: DIFF=1110 (−2), overflow=0, done high for 1 cycle, busy high for 4 cycles.
- A=0111 (7), B=1111 (−1) → DIFF=1000, overflow=1. Then A=1000 (−8), B=0001 → DIFF=0111, overflow=1.
- A=1000, B=1000 → DIFF=0000, overflow=0. A=0000, B=1000 → DIFF=1000, overflow=1.
- Drive `start` every cycle with changing operands → only the values present on the accept edges are used. Results arrive 5 cycles apart, and DIFF stays stable between done pulses.
- Assert `rst` for one cycle after bit 2 of 6−2 → no done pulse; all outputs 0. The next start with 6−2 yields DIFF=0100 with no residue from the aborted operation.
- Exhaustive sweep of all 256 (A,B) pairs → DIFF and overflow match a signed reference model for every pair.
